// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM output stage: FSM states,
// function-select encodings and the default counter width.
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [1:0] FN_LEFT      = 2'b00;
    localparam logic [1:0] FN_RIGHT     = 2'b01;
    localparam int         FN_RANGE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } pwm_state_e;

endpackage

// File: rtl/pwm_compare.sv
// Combinational compare stage: turns the current count and the active
// compare set into the raw PWM level.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic [CNT_W-1:0] count_val_i,
    input  logic [CNT_W-1:0] cmp1_i,
    input  logic [CNT_W-1:0] cmp2_i,
    input  logic [CNT_W-1:0] per_i,
    input  logic [1:0]       func_i,
    output logic             level_o
);

    logic cmp1_beyond;

    // A first compare past the period pins left/right modes to a constant level,
    // even if the counter momentarily runs past the shadowed period.
    always_comb begin
        cmp1_beyond = (cmp1_i > per_i);
        level_o     = 1'b0;
        if (func_i[FN_RANGE_BIT]) begin
            level_o = (count_val_i >= cmp1_i) && (count_val_i < cmp2_i);
        end else if (func_i == FN_RIGHT) begin
            level_o = (count_val_i >= cmp1_i) && !cmp1_beyond;
        end else begin
            level_o = (count_val_i < cmp1_i) || cmp1_beyond;
        end
    end

endmodule

// File: rtl/pwm_output_gen.sv
// PWM output stage: detects period boundaries on the incoming count, holds
// double-buffered compare settings and drives a registered pwm_out.
module pwm_output_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] count_val,
    input  logic             upnotdown,
    input  logic             count_reset,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] compare1,
    input  logic [CNT_W-1:0] compare2,
    input  logic [1:0]       functions,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cmp1_s_q, cmp1_s_d;
    logic [CNT_W-1:0] cmp2_s_q, cmp2_s_d;
    logic [CNT_W-1:0] per_s_q, per_s_d;
    logic [1:0]       func_s_q, func_s_d;
    logic             pwm_out_q, period_done_q, busy_q;
    logic             wrap, boundary, load_shadow, raw_level;

    always_comb begin
        wrap     = (count_val != cnt_q) &&
                   (upnotdown ? (count_val < cnt_q) : (count_val > cnt_q));
        boundary = wrap | count_reset;
    end

    // Shadows reload only when a new period starts under RUN, or on enabling from IDLE.
    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pwm_en) begin
                    state_d     = ST_RUN;
                    load_shadow = 1'b1;
                end
            end
            ST_RUN: begin
                load_shadow = boundary;
                if (!pwm_en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pwm_en)        state_d = ST_RUN;
                else if (boundary) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The compare sees freshly loaded values so a new period applies from its first count.
    always_comb begin
        cmp1_s_d = load_shadow ? compare1  : cmp1_s_q;
        cmp2_s_d = load_shadow ? compare2  : cmp2_s_q;
        per_s_d  = load_shadow ? period    : per_s_q;
        func_s_d = load_shadow ? functions : func_s_q;
    end

    pwm_compare #(
        .CNT_W(CNT_W)
    ) u_compare (
        .count_val_i(count_val),
        .cmp1_i     (cmp1_s_d),
        .cmp2_i     (cmp2_s_d),
        .per_i      (per_s_d),
        .func_i     (func_s_d),
        .level_o    (raw_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmp1_s_q      <= '0;
            cmp2_s_q      <= '0;
            per_s_q       <= '0;
            func_s_q      <= '0;
            pwm_out_q     <= 1'b0;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= count_val;
            cmp1_s_q      <= cmp1_s_d;
            cmp2_s_q      <= cmp2_s_d;
            per_s_q       <= per_s_d;
            func_s_q      <= func_s_d;
            pwm_out_q     <= (state_d != ST_IDLE) && raw_level;
            period_done_q <= boundary && (state_q != ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign pwm_out     = pwm_out_q;
    assign period_done = period_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_output_gen.sv
// Self-checking bench for pwm_output_gen: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_pwm_output_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstN;
    logic         pwmEn;
    logic [W-1:0] countVal;
    logic         upNotDown;
    logic         countReset;
    logic [W-1:0] period;
    logic [W-1:0] compare1;
    logic [W-1:0] compare2;
    logic [1:0]   functions;
    logic         pwmOut;
    logic         periodDone;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int           mState;
    logic [W-1:0] mPrev, mC1, mC2, mPer;
    logic [1:0]   mFn;
    logic [2:0]   expVec;

    pwm_output_gen #(.CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .pwm_en     (pwmEn),
        .count_val  (countVal),
        .upnotdown  (upNotDown),
        .count_reset(countReset),
        .period     (period),
        .compare1   (compare1),
        .compare2   (compare2),
        .functions  (functions),
        .pwm_out    (pwmOut),
        .period_done(periodDone),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Level the output should have for one count value under a given setting.
    function automatic logic refLevel(logic [W-1:0] v, logic [W-1:0] c1, logic [W-1:0] c2,
                                      logic [W-1:0] per, logic [1:0] fn);
        if (fn[1]) return (v >= c1) && (v < c2);
        if (fn[0]) return (c1 <= per) && (v >= c1);
        return (c1 > per) || (v < c1);
    endfunction

    task automatic modelReset();
        mState = 0;
        mPrev  = '0;
        mC1    = '0;
        mC2    = '0;
        mPer   = '0;
        mFn    = 2'b00;
        expVec = 3'b000;
    endtask

    // States as numbers: 0 idle, 1 running, 2 finishing the current period.
    task automatic applyStimulus();
        bit wrapped, bnd, doneE, lvl;
        int ns;
        wrapped = (countVal != mPrev) && (upNotDown ? (countVal < mPrev) : (countVal > mPrev));
        bnd     = wrapped || countReset;
        doneE   = bnd && (mState != 0);
        ns      = mState;
        if ((mState == 0 && pwmEn) || (mState == 1 && bnd)) begin
            mC1 = compare1; mC2 = compare2; mPer = period; mFn = functions;
        end
        if (mState == 0)      ns = pwmEn ? 1 : 0;
        else if (mState == 1) ns = pwmEn ? 1 : 2;
        else                  ns = pwmEn ? 1 : (bnd ? 0 : 2);
        lvl    = (ns != 0) && refLevel(countVal, mC1, mC2, mPer, mFn);
        expVec = {lvl, doneE, ns != 0};
        mState = ns;
        mPrev  = countVal;
        @(posedge clk);
        #1;
    endtask

    task automatic nextCount();
        if (upNotDown) countVal = (countVal >= period) ? '0 : countVal + 1'b1;
        else           countVal = (countVal == 0 || countVal > period) ? period : countVal - 1'b1;
    endtask

    task automatic startIdle();
        pwmEn      = 1'b0;
        countReset = 1'b0;
        for (int k = 0; k < 60 && mState != 0; k++) begin
            nextCount();
            applyStimulus();
        end
        countVal  = '0;
        upNotDown = 1'b1;
        applyStimulus();
    endtask

    task automatic test_reset();
        rstN = 1'b0; pwmEn = 1'b0; countVal = '0; upNotDown = 1'b1; countReset = 1'b0;
        period = 16'd9; compare1 = '0; compare2 = '0; functions = 2'b00;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pwmOut !== 1'b0)     begin errors++; $display("[TB] FAIL reset_pwm_out got %b want 0", pwmOut); end
        checks++; if (periodDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_done got %b want 0", periodDone); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        rstN = 1'b1;
        applyStimulus();
    endtask

    task automatic test_left_align();
        int highs = 0, dones = 0;
        startIdle();
        period = 16'd9; functions = 2'b00; compare1 = 16'd3; pwmEn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) nextCount();
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL left_align step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            if (i >= 10 && i < 30) begin highs += pwmOut; dones += periodDone; end
        end
        checks++; if (highs != 6) begin errors++; $display("[TB] FAIL left_align_high_cycles got %0d want 6", highs); end
        checks++; if (dones != 2) begin errors++; $display("[TB] FAIL left_align_done_pulses got %0d want 2", dones); end
    endtask

    task automatic test_compare_change();
        int highsA = 0, highsB = 0;
        startIdle();
        period = 16'd9; functions = 2'b00; compare1 = 16'd3; pwmEn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) nextCount();
            if (i < 10 && countVal == 16'd5) compare1 = 16'd6;
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL compare_change step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            if (i < 10) highsA += pwmOut;
            else if (i < 20) highsB += pwmOut;
        end
        checks++; if (highsA != 3) begin errors++; $display("[TB] FAIL compare_change_old_period got %0d want 3", highsA); end
        checks++; if (highsB != 6) begin errors++; $display("[TB] FAIL compare_change_new_period got %0d want 6", highsB); end
    endtask

    task automatic test_range();
        int highsA = 0, highsB = 0;
        startIdle();
        period = 16'd7; functions = 2'b10; compare1 = 16'd2; compare2 = 16'd5; pwmEn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) nextCount();
            if (i == 16) begin compare1 = 16'd5; compare2 = 16'd2; end
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL range step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            if (i >= 8 && i < 16) highsA += pwmOut;
            else if (i >= 16) highsB += pwmOut;
        end
        checks++; if (highsA != 3) begin errors++; $display("[TB] FAIL range_window got %0d want 3", highsA); end
        checks++; if (highsB != 0) begin errors++; $display("[TB] FAIL range_inverted got %0d want 0", highsB); end
    endtask

    task automatic test_constant_levels();
        int highs[4] = '{0, 0, 0, 0};
        startIdle();
        period = 16'd9; functions = 2'b00; compare1 = 16'd0; pwmEn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) nextCount();
            if (i == 10) compare1 = 16'd12;
            if (i == 20) begin functions = 2'b01; compare1 = 16'd0; end
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL constant_levels step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            highs[i / 10] += pwmOut;
        end
        checks++; if (highs[0] != 0)  begin errors++; $display("[TB] FAIL left_cmp_zero got %0d want 0", highs[0]); end
        checks++; if (highs[1] != 10) begin errors++; $display("[TB] FAIL left_cmp_beyond got %0d want 10", highs[1]); end
        checks++; if (highs[2] != 10) begin errors++; $display("[TB] FAIL right_cmp_zero got %0d want 10", highs[2]); end
    endtask

    task automatic test_drain();
        startIdle();
        period = 16'd9; functions = 2'b00; compare1 = 16'd3; pwmEn = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (i > 0) nextCount();
            if (i == 14 || i == 26) pwmEn = 1'b0;
            if (i == 24 || i == 28) pwmEn = 1'b1;
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL drain step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            if (i == 20) begin
                checks++;
                if ({pwmOut, periodDone, busy} !== 3'b010) begin
                    errors++; $display("[TB] FAIL drain_to_idle got %b want 010", {pwmOut, periodDone, busy});
                end
            end
            if (i == 31) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_reenable_busy got %b want 1", busy); end
            end
        end
    endtask

    task automatic test_down_and_async_reset();
        int highs = 0, dones = 0;
        startIdle();
        upNotDown = 1'b0; period = 16'd9; functions = 2'b01; compare1 = 16'd4;
        countVal = 16'd9; pwmEn = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) nextCount();
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL down_count step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
            if (i >= 1 && i < 20) dones += periodDone;
            if (i >= 10 && i < 20) highs += pwmOut;
        end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL down_wrap_done got %0d want 1", dones); end
        checks++; if (highs != 6) begin errors++; $display("[TB] FAIL down_right_high got %0d want 6", highs); end
        #3 rstN = 1'b0;
        #1;
        checks++;
        if ({pwmOut, periodDone, busy} !== 3'b000) begin
            errors++; $display("[TB] FAIL async_reset got %b want 000", {pwmOut, periodDone, busy});
        end
        @(posedge clk);
        #1 rstN = 1'b1;
        modelReset();
        for (int i = 0; i < 15; i++) begin
            nextCount();
            applyStimulus();
            checks++;
            if ({pwmOut, periodDone, busy} !== expVec) begin
                errors++; $display("[TB] FAIL after_reset step %0d got %b want %b", i, {pwmOut, periodDone, busy}, expVec);
            end
        end
    endtask

    task automatic test_random();
        startIdle();
        for (int seg = 0; seg < 2; seg++) begin
            upNotDown = (seg == 0);
            pwmEn     = 1'b1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(29, 0) == 0) pwmEn = ~pwmEn;
                if ($urandom_range(14, 0) == 0) begin
                    period    = W'($urandom_range(20, 3));
                    compare1  = W'($urandom_range(int'(period) + 3, 0));
                    compare2  = W'($urandom_range(int'(period) + 3, 0));
                    functions = 2'($urandom_range(3, 0));
                end
                if ($urandom_range(39, 0) == 0) begin
                    countReset = 1'b1;
                    countVal   = '0;
                end else begin
                    countReset = 1'b0;
                    if ($urandom_range(5, 0) != 0) nextCount();
                end
                applyStimulus();
                checks++;
                if ({pwmOut, periodDone, busy} !== expVec) begin
                    errors++; $display("[TB] FAIL random seg %0d step %0d got %b want %b", seg, i, {pwmOut, periodDone, busy}, expVec);
                end
            end
        end
        countReset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_left_align();
        test_compare_change();
        test_range();
        test_constant_levels();
        test_drain();
        test_down_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
